// File: rtl/trap_csr_unit.sv
// trap_csr_unit: machine-mode trap controller and trap CSR file.
// Holds mstatus/mie/mtvec/mepc/mcause/mip and synchronises the external
// interrupt lines. It arbitrates exceptions, MRET and interrupts in EX and
// issues a one-cycle redirect pulse. After each redirect it ignores new
// events while the pipeline drains.
// Optional feature: define TRAP_VECTORED_EN to enable vectored interrupt
// dispatch (mtvec[1:0]=01).
module trap_csr_unit #(
    parameter int unsigned     NUM_IRQ      = 4,
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET  = 32'h0000_0100,
    parameter int unsigned     DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               csr_valid,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    input  logic               exc_valid,
    input  logic [4:0]         exc_cause,
    input  logic [XLEN-1:0]    ex_pc,
    input  logic               ex_live,
    input  logic               mret_valid,
    output logic               trap_redirect,
    output logic [XLEN-1:0]    trap_target,
    output logic [NUM_IRQ-1:0] irq_pending
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        ST_RUN,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    state_t             state;
    logic [2:0]         drain_cnt;
    logic [NUM_IRQ-1:0] irq_sync1;
    logic [NUM_IRQ-1:0] irq_sync2;

    logic               mstatus_mie;
    logic               mstatus_mpie;
    logic [NUM_IRQ-1:0] mie_q;
    logic [XLEN-1:0]    mtvec_q;
    logic [XLEN-1:0]    mepc_q;
    logic [XLEN-1:0]    mcause_q;

    logic               trap_redirect_q;
    logic [XLEN-1:0]    trap_target_q;

    logic [XLEN-1:0]    mstatus_val;
    logic [XLEN-1:0]    mepc_val;
    logic [XLEN-1:0]    mtvec_base;
    logic [NUM_IRQ-1:0] irq_active;
    logic               irq_any;
    logic [3:0]         irq_idx;
    logic [4:0]         irq_code;

    logic               in_run;
    logic               take_exc;
    logic               take_mret;
    logic               take_irq;
    logic               take_trap;
    logic               csr_we;
    logic [XLEN-1:0]    csr_wval;
    logic [XLEN-1:0]    trap_cause;
    logic [XLEN-1:0]    trap_vector;

    assign trap_redirect = trap_redirect_q;
    assign trap_target   = trap_target_q;
    assign irq_pending   = irq_sync2;

    // Assemble the architectural views of mstatus, mepc and the trap base.
    always_comb begin
        mstatus_val    = '0;
        mstatus_val[3] = mstatus_mie;
        mstatus_val[7] = mstatus_mpie;
        mepc_val       = mepc_q & ALIGN_MASK;
        mtvec_base     = mtvec_q & ALIGN_MASK;
    end

    // Pick the lowest-index line that is both pending and enabled.
    always_comb begin
        irq_active = irq_sync2 & mie_q;
        irq_any    = |irq_active;
        irq_idx    = '0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (irq_active[i-1]) begin
                irq_idx = 4'(i - 1);
            end
        end
        irq_code = 5'd16 + {1'b0, irq_idx};
    end

    // Event arbitration: exception over MRET over interrupt, RUN state only.
    always_comb begin
        in_run    = (state == ST_RUN);
        take_exc  = in_run && exc_valid;
        take_mret = in_run && !exc_valid && mret_valid;
        take_irq  = in_run && !exc_valid && !mret_valid && ex_live
                    && mstatus_mie && irq_any;
        take_trap = take_exc || take_irq;
        csr_we    = in_run && csr_valid && (csr_op != 2'b00)
                    && !take_trap && !take_mret;
    end

    // Combinational read of the addressed CSR (old value).
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = mstatus_val;
            CSR_MIE:     csr_rdata = {{(XLEN-NUM_IRQ){1'b0}}, mie_q};
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_MEPC:    csr_rdata = mepc_val;
            CSR_MCAUSE:  csr_rdata = mcause_q;
            CSR_MIP:     csr_rdata = {{(XLEN-NUM_IRQ){1'b0}}, irq_sync2};
            default:     csr_rdata = '0;
        endcase
    end

    // New CSR value for read-write, read-set and read-clear operations.
    always_comb begin
        case (csr_op)
            2'b01:   csr_wval = csr_wdata;
            2'b10:   csr_wval = csr_rdata | csr_wdata;
            2'b11:   csr_wval = csr_rdata & ~csr_wdata;
            default: csr_wval = csr_rdata;
        endcase
    end

    // Trap cause and redirect address for an accepted exception or interrupt.
    always_comb begin
        if (take_exc) begin
            trap_cause = {{(XLEN-5){1'b0}}, exc_cause};
        end else begin
            trap_cause = {1'b1, {(XLEN-6){1'b0}}, irq_code};
        end
`ifdef TRAP_VECTORED_EN
        if (take_irq && (mtvec_q[1:0] == 2'b01)) begin
            trap_vector = mtvec_base + {{(XLEN-7){1'b0}}, irq_code, 2'b00};
        end else begin
            trap_vector = mtvec_base;
        end
`else
        trap_vector = mtvec_base;
`endif
    end

    // Two-flop synchroniser on the asynchronous interrupt lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_sync1 <= '0;
            irq_sync2 <= '0;
        end else begin
            irq_sync1 <= irq_in;
            irq_sync2 <= irq_sync1;
        end
    end

    // RUN -> ISSUE -> DRAIN -> RUN sequencing with the registered redirect pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_RUN;
            drain_cnt       <= '0;
            trap_redirect_q <= 1'b0;
            trap_target_q   <= '0;
        end else begin
            trap_redirect_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (take_trap || take_mret) begin
                        state           <= ST_ISSUE;
                        trap_redirect_q <= 1'b1;
                        trap_target_q   <= take_mret ? mepc_val : trap_vector;
                    end
                end
                ST_ISSUE: begin
                    state     <= ST_DRAIN;
                    drain_cnt <= 3'(DRAIN_CYCLES - 1);
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // CSR state: trap/MRET side effects take precedence over software writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= '0;
            mtvec_q      <= MTVEC_RESET;
            mepc_q       <= '0;
            mcause_q     <= '0;
        end else if (take_trap) begin
            mepc_q       <= ex_pc & ALIGN_MASK;
            mcause_q     <= trap_cause;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (take_mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie  <= csr_wval[3];
                    mstatus_mpie <= csr_wval[7];
                end
                CSR_MIE:    mie_q <= csr_wval[NUM_IRQ-1:0];
`ifdef TRAP_VECTORED_EN
                CSR_MTVEC:  mtvec_q <= csr_wval;
`else
                CSR_MTVEC:  mtvec_q <= csr_wval & ALIGN_MASK;
`endif
                CSR_MEPC:   mepc_q   <= csr_wval & ALIGN_MASK;
                CSR_MCAUSE: mcause_q <= csr_wval;
                default:    ;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_csr_unit.sv
// tb_trap_csr_unit: directed scenarios followed by a random phase. Every
// cycle is checked against a behavioural model of the trap rules.
module tb_trap_csr_unit;

    localparam int unsigned NIRQ  = 4;
    localparam int unsigned DRAIN = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NIRQ-1:0] irq_in;
    logic            csr_valid;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [31:0]     csr_wdata;
    logic [31:0]     csr_rdata;
    logic            exc_valid;
    logic [4:0]      exc_cause;
    logic [31:0]     ex_pc;
    logic            ex_live;
    logic            mret_valid;
    logic            trap_redirect;
    logic [31:0]     trap_target;
    logic [NIRQ-1:0] irq_pending;

    always #10 clk = ~clk;

    trap_csr_unit #(
        .NUM_IRQ(NIRQ),
        .XLEN(32),
        .MTVEC_RESET(32'h0000_0100),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .irq_in(irq_in),
        .csr_valid(csr_valid),
        .csr_op(csr_op),
        .csr_addr(csr_addr),
        .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata),
        .exc_valid(exc_valid),
        .exc_cause(exc_cause),
        .ex_pc(ex_pc),
        .ex_live(ex_live),
        .mret_valid(mret_valid),
        .trap_redirect(trap_redirect),
        .trap_target(trap_target),
        .irq_pending(irq_pending)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [31:0]     r_mstatus, r_mie, r_mtvec, r_mepc, r_mcause;
    logic [NIRQ-1:0] irq_hist[$];
    int              blocked;
    logic            exp_redirect;
    logic [31:0]     exp_target;

    logic [11:0] addr_list [8] = '{12'h300, 12'h304, 12'h305, 12'h341,
                                   12'h342, 12'h344, 12'h340, 12'h7C0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mip is whatever irq_in was two clock edges ago.
    function automatic logic [NIRQ-1:0] ref_mip();
        if (irq_hist.size() == 2) return irq_hist[0];
        return '0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [11:0] a);
        case (a)
            12'h300: return r_mstatus;
            12'h304: return r_mie;
            12'h305: return r_mtvec;
            12'h341: return r_mepc;
            12'h342: return r_mcause;
            12'h344: return 32'(ref_mip());
            default: return 32'h0;
        endcase
    endfunction

    function automatic void take_trap(input logic [31:0] cause, input logic [31:0] tgt);
        r_mepc       = ex_pc & ~32'h3;
        r_mcause     = cause;
        r_mstatus    = r_mstatus[3] ? 32'h80 : 32'h00;
        exp_target   = tgt;
        exp_redirect = 1'b1;
        blocked      = 1 + DRAIN;
    endfunction

    // Apply one clock edge's worth of architectural rules to the model.
    function automatic void model_edge();
        logic [NIRQ-1:0] pend;
        logic [31:0]     nv, old, tgt;
        int              idx;
        pend = ref_mip() & r_mie[NIRQ-1:0];
        exp_redirect = 1'b0;
        if (reset) begin
            r_mstatus = 0; r_mie = 0; r_mepc = 0; r_mcause = 0;
            r_mtvec = 32'h100; exp_target = 0; blocked = 0;
            irq_hist.delete();
            return;
        end
        if (blocked > 0) begin
            blocked--;
        end else if (exc_valid) begin
            take_trap(32'(exc_cause), r_mtvec & ~32'h3);
        end else if (mret_valid) begin
            r_mstatus    = r_mstatus[7] ? 32'h88 : 32'h80;
            exp_target   = r_mepc;
            exp_redirect = 1'b1;
            blocked      = 1 + DRAIN;
        end else if (ex_live && r_mstatus[3] && pend != 0) begin
            idx = 0;
            for (int i = NIRQ - 1; i >= 0; i--) if (pend[i]) idx = i;
            tgt = r_mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
            if ((r_mtvec & 32'h3) == 32'h1) tgt = tgt + 4 * (16 + idx);
`endif
            take_trap(32'h8000_0000 + 32'(16 + idx), tgt);
        end else if (csr_valid && csr_op != 2'b00) begin
            old = ref_read(csr_addr);
            case (csr_op)
                2'b01:   nv = csr_wdata;
                2'b10:   nv = old | csr_wdata;
                default: nv = old & ~csr_wdata;
            endcase
            case (csr_addr)
                12'h300: r_mstatus = nv & 32'h88;
                12'h304: r_mie     = nv & ((32'h1 << NIRQ) - 1);
`ifdef TRAP_VECTORED_EN
                12'h305: r_mtvec   = nv;
`else
                12'h305: r_mtvec   = nv & ~32'h3;
`endif
                12'h341: r_mepc    = nv & ~32'h3;
                12'h342: r_mcause  = nv;
                default: ;
            endcase
        end
        irq_hist.push_back(irq_in);
        if (irq_hist.size() > 2) void'(irq_hist.pop_front());
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("redirect", 32'(trap_redirect), 32'(exp_redirect));
        chk("irq_pending", 32'(irq_pending), 32'(ref_mip()));
        if (exp_redirect) chk("target", trap_target, exp_target);
    endtask

    task automatic idle();
        exc_valid = 0; mret_valid = 0; csr_valid = 0; csr_op = 2'b00;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic check_csrs();
        csr_valid = 0;
        foreach (addr_list[k]) begin
            csr_addr = addr_list[k];
            #1;
            chk($sformatf("csr_%h", addr_list[k]), csr_rdata, ref_read(addr_list[k]));
        end
    endtask

    task automatic csr_write(input logic [1:0] op, input logic [11:0] a, input logic [31:0] w);
        csr_valid = 1; csr_op = op; csr_addr = a; csr_wdata = w;
        tick();
        idle();
    endtask

    initial begin
        reset = 1; irq_in = '0; idle(); ex_live = 0; ex_pc = 0; exc_cause = 0;
        csr_addr = 0; csr_wdata = 0;
        r_mstatus = 0; r_mie = 0; r_mtvec = 0; r_mepc = 0; r_mcause = 0;
        blocked = 0; exp_redirect = 0; exp_target = 0;

        // Reset values
        tick(); tick();
        chk("rst_redirect", 32'(trap_redirect), 32'h0);
        chk("rst_target", trap_target, 32'h0);
        rd_chk("rst_mtvec", 12'h305, 32'h100);
        check_csrs();
        reset = 0;

        // Exception redirects to mtvec base
        csr_write(2'b01, 12'h305, 32'h200);
        exc_valid = 1; exc_cause = 5'd2; ex_pc = 32'h40; ex_live = 1;
        tick(); idle();
        chk("exc_redirect", 32'(trap_redirect), 32'h1);
        chk("exc_target", trap_target, 32'h200);
        rd_chk("exc_mepc", 12'h341, 32'h40);
        rd_chk("exc_mcause", 12'h342, 32'h2);
        rd_chk("exc_mstatus", 12'h300, 32'h0);
        repeat (3) tick();

        // Interrupt via synchroniser, lowest of two pending lines
        csr_write(2'b01, 12'h300, 32'h8);
        csr_write(2'b01, 12'h304, 32'h6);
        ex_pc = 32'h1234; irq_in = 4'b0110;
        tick(); chk("irq_e1", 32'(trap_redirect), 32'h0);
        tick(); chk("irq_e2", 32'(trap_redirect), 32'h0);
        tick(); chk("irq_e3", 32'(trap_redirect), 32'h1);
        chk("irq_target", trap_target, 32'h200);
        chk("irq_pend", 32'(irq_pending), 32'h6);
        rd_chk("irq_mcause", 12'h342, 32'h8000_0011);
        rd_chk("irq_mstatus", 12'h300, 32'h80);
        irq_in = '0;
        repeat (3) tick();

        // MRET returns to mepc with a single-cycle pulse
        mret_valid = 1;
        tick(); idle();
        chk("mret_redirect", 32'(trap_redirect), 32'h1);
        chk("mret_target", trap_target, 32'h1234);
        rd_chk("mret_mstatus", 12'h300, 32'h88);
        tick();
        chk("mret_pulse_end", 32'(trap_redirect), 32'h0);
        repeat (2) tick();

        // Exception beats MRET and CSR write; events in DRAIN are squashed
        exc_valid = 1; exc_cause = 5'd5; mret_valid = 1; ex_pc = 32'h80;
        csr_valid = 1; csr_op = 2'b01; csr_addr = 12'h341; csr_wdata = 32'hDEAD_0000;
        tick(); idle();
        chk("coll_redirect", 32'(trap_redirect), 32'h1);
        chk("coll_target", trap_target, 32'h200);
        rd_chk("coll_mepc", 12'h341, 32'h80);
        rd_chk("coll_mcause", 12'h342, 32'h5);
        exc_valid = 1; exc_cause = 5'd7; ex_pc = 32'h99C;
        tick(); chk("squash_issue", 32'(trap_redirect), 32'h0);
        tick(); chk("squash_drain", 32'(trap_redirect), 32'h0);
        idle();
        tick();
        rd_chk("squash_mepc", 12'h341, 32'h80);

        // Pending interrupt waits for ex_live; reset during DRAIN
        csr_write(2'b10, 12'h300, 32'h8);
        irq_in = 4'b0010; ex_live = 0; ex_pc = 32'h500;
        repeat (5) begin
            tick();
            chk("nolive", 32'(trap_redirect), 32'h0);
        end
        ex_live = 1;
        tick();
        chk("live_redirect", 32'(trap_redirect), 32'h1);
        rd_chk("live_mcause", 12'h342, 32'h8000_0011);
        rd_chk("live_mepc", 12'h341, 32'h500);
        tick();
        irq_in = '0; reset = 1;
        tick();
        reset = 0;
        chk("rst_drain_redirect", 32'(trap_redirect), 32'h0);
        exc_valid = 1; exc_cause = 5'd3; ex_pc = 32'h44;
        tick(); idle();
        chk("rst_drain_run", 32'(trap_redirect), 32'h1);
        chk("rst_drain_target", trap_target, 32'h100);
        repeat (3) tick();

        // Vectored dispatch (or base-only without the feature)
        csr_write(2'b01, 12'h305, 32'h301);
`ifdef TRAP_VECTORED_EN
        rd_chk("vec_mtvec", 12'h305, 32'h301);
`else
        rd_chk("vec_mtvec", 12'h305, 32'h300);
`endif
        csr_write(2'b01, 12'h300, 32'h8);
        csr_write(2'b01, 12'h304, 32'h1);
        irq_in = 4'b0001; ex_live = 1;
        repeat (3) tick();
        chk("vec_redirect", 32'(trap_redirect), 32'h1);
`ifdef TRAP_VECTORED_EN
        chk("vec_target", trap_target, 32'h340);
`else
        chk("vec_target", trap_target, 32'h300);
`endif
        irq_in = '0;
        repeat (3) tick();
        check_csrs();

        // Random phase against the model
        for (int c = 0; c < 600; c++) begin
            logic [11:0] a;
            a = addr_list[$urandom_range(0, 7)];
            csr_valid = 0; csr_addr = a;
            #1;
            chk("rnd_rd", csr_rdata, ref_read(a));
            reset      = ($urandom_range(0, 99) == 0);
            exc_valid  = ($urandom_range(0, 99) < 8);
            exc_cause  = 5'($urandom);
            mret_valid = ($urandom_range(0, 99) < 8);
            csr_valid  = ($urandom_range(0, 99) < 35);
            csr_op     = 2'($urandom);
            csr_addr   = addr_list[$urandom_range(0, 7)];
            csr_wdata  = $urandom;
            ex_pc      = $urandom;
            ex_live    = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 9) == 0) irq_in = NIRQ'($urandom);
            tick();
        end
        reset = 0; idle();
        tick();
        check_csrs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
